// File: rtl/mult_fu.sv
// mult_fu: pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU).
// Ports: clock/reset (async, active-high); fu_packet (issued op), squash
// (flush), cdb_gnt (grant of the held result); avail (op accepted this cycle);
// result_valid/value/prn/robn (held result waiting for the CDB).
// Optional feature macro MULT_EARLY_TAG_EN adds early_tag_valid/early_tag_prn,
// a one-cycle-early wakeup tag for the reservation station.

package mult_fu_pkg;
    localparam int DATA_WIDTH    = 32;
    localparam int PRN_WIDTH     = 6;
    localparam int ROB_CNT_WIDTH = 5;

    typedef logic [DATA_WIDTH-1:0] DATA;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MULT_FUNC;

    typedef struct packed {
        logic                     valid;
        MULT_FUNC                 func;
        DATA                      op1;
        DATA                      op2;
        logic [PRN_WIDTH-1:0]     dest_prn;
        logic [ROB_CNT_WIDTH-1:0] robn;
    } FU_PACKET;
endpackage

// Purpose: multiply unit, 64/NUM_STAGES multiplier bits consumed per stage.
// Latency: NUM_STAGES edges after the accept edge until result_valid is high.
// Backpressure: held result without cdb_gnt freezes the whole pipe; avail=0.
module mult_fu
    import mult_fu_pkg::*;
#(
    parameter int NUM_STAGES = 4    // legal: 1, 2, 4, 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  FU_PACKET                 fu_packet,
    input  logic                     squash,
    input  logic                     cdb_gnt,
    output logic                     avail,
    output logic                     result_valid,
    output DATA                      result_value,
    output logic [PRN_WIDTH-1:0]     result_prn,
    output logic [ROB_CNT_WIDTH-1:0] result_robn
`ifdef MULT_EARLY_TAG_EN
    ,
    output logic                     early_tag_valid,
    output logic [PRN_WIDTH-1:0]     early_tag_prn
`endif
);

    // Multiplier bits consumed by each stage.
    localparam int CH = 64 / NUM_STAGES;

    typedef struct packed {
        MULT_FUNC                 func;
        logic [PRN_WIDTH-1:0]     prn;
        logic [ROB_CNT_WIDTH-1:0] robn;
        logic [63:0]              mcand;
        logic [63:0]              mplier;
        logic [63:0]              sum;
    } stage_t;

    // Operand extension at accept. Everything downstream is plain unsigned
    // mod-2^64 arithmetic, so signedness lives entirely in this extension.
    function automatic stage_t prep(input FU_PACKET p);
        stage_t s;
        s.func   = p.func;
        s.prn    = p.dest_prn;
        s.robn   = p.robn;
        s.mcand  = (p.func == MULH || p.func == MULHSU) ?
                   {{32{p.op1[31]}}, p.op1} : {32'b0, p.op1};
        s.mplier = (p.func == MULH) ? {{32{p.op2[31]}}, p.op2} : {32'b0, p.op2};
        s.sum    = 64'd0;
        return s;
    endfunction

    // One partial-product step: accumulate mcand * low CH multiplier bits,
    // then line the operands up for the next chunk.
    function automatic stage_t step(input stage_t s);
        stage_t r;
        r        = s;
        r.sum    = s.sum + s.mcand * 64'(s.mplier[CH-1:0]);
        r.mcand  = s.mcand << CH;
        r.mplier = s.mplier >> CH;
        return r;
    endfunction

    logic [NUM_STAGES-1:0] stage_vld;
    stage_t                stage_dat [NUM_STAGES];
    stage_t                stage_nxt [NUM_STAGES];
    stage_t                entry_dat;
    stage_t                fin_dat;
    DATA                   fin_value;
    logic                  fin_vld;
    logic                  stall;
    logic                  advance;

    assign stall   = result_valid & ~cdb_gnt;
    assign advance = ~stall;
    assign avail   = advance;

    always_comb begin
        entry_dat = prep(fu_packet);
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_nxt[k] = step(stage_dat[k]);
        end
        fin_dat   = stage_nxt[NUM_STAGES-1];
        fin_vld   = stage_vld[NUM_STAGES-1];
        fin_value = (fin_dat.func == MUL) ? fin_dat.sum[31:0] : fin_dat.sum[63:32];
    end

    // Stage 0 holds the prepared operands; each later stage holds the previous
    // stage after its step, and the output register takes the final step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_vld <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_dat[k] <= '0;
            end
        end else if (advance) begin
            if (squash) begin
                stage_vld <= '0;
            end else begin
                stage_vld[0] <= fu_packet.valid;
                for (int k = 1; k < NUM_STAGES; k++) begin
                    stage_vld[k] <= stage_vld[k-1];
                end
            end
            stage_dat[0] <= entry_dat;
            for (int k = 1; k < NUM_STAGES; k++) begin
                stage_dat[k] <= stage_nxt[k-1];
            end
        end else if (squash) begin
            stage_vld <= '0;
        end
    end

    // Output register. When advancing, result_valid simply follows the final
    // stage valid: this covers back-to-back load on grant and clear on grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_valid <= 1'b0;
            result_value <= '0;
            result_prn   <= '0;
            result_robn  <= '0;
        end else begin
            if (squash) begin
                result_valid <= 1'b0;
            end else if (advance) begin
                result_valid <= fin_vld;
            end
            if (advance && fin_vld && !squash) begin
                result_value <= fin_value;
                result_prn   <= fin_dat.prn;
                result_robn  <= fin_dat.robn;
            end
        end
    end

`ifdef MULT_EARLY_TAG_EN
    // Exactly the condition under which result_valid rises next edge.
    assign early_tag_valid = fin_vld & advance & ~squash;
    assign early_tag_prn   = early_tag_valid ? stage_dat[NUM_STAGES-1].prn : '0;
`endif

endmodule
